// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: shared prescaled PWM timebase with per-channel OFF/ON/BLINK/PWM modes.
// Duty updates are double-buffered and land on frame wrap so a running PWM output never glitches.
module led_pwm_ctrl #(
    parameter int N_LEDS       = 4,
    parameter int PWM_W        = 8,
    parameter int TICK_DIV     = 100,
    parameter int BLINK_FRAMES = 2048,
    localparam int CH_W        = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic              clk_100_i,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [PWM_W-1:0]  cfg_duty_i,
    output logic [N_LEDS-1:0] leds_o,
    output logic              frame_o
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } led_mode_e;

    logic [PRE_W-1:0] pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;
    logic             tick;
    logic             wrap;

    led_mode_e        mode_q      [N_LEDS];
    logic [PWM_W-1:0] duty_shadow [N_LEDS];
    logic [PWM_W-1:0] duty_active [N_LEDS];
    logic [N_LEDS-1:0] ch_sel;
    logic [N_LEDS-1:0] leds_next;

    assign tick = (pre_cnt == PRE_LAST);
    assign wrap = tick && (&pwm_cnt);

    // Timebase: prescaler -> PWM counter -> frame counter -> blink phase.
    always_ff @(posedge clk_100_i) begin
        if (rst_i) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_o     <= 1'b0;
        end else begin
            frame_o <= wrap;
            if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end
            if (wrap) begin
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FRM_W'(1);
                end
            end
        end
    end

    // Out-of-range channel indices match no decode line, so such writes vanish.
    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            ch_sel[i] = cfg_we_i && (cfg_ch_i == CH_W'(i));
        end
    end

    always_ff @(posedge clk_100_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_LEDS; i++) begin
                mode_q[i]      <= MODE_OFF;
                duty_shadow[i] <= '0;
                duty_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                if (ch_sel[i]) begin
                    mode_q[i]      <= led_mode_e'(cfg_mode_i);
                    duty_shadow[i] <= cfg_duty_i;
                end
                // A write landing on the wrap cycle bypasses the shadow so it is not lost for a frame.
                if (wrap) begin
                    duty_active[i] <= ch_sel[i] ? cfg_duty_i : duty_shadow[i];
                end
            end
        end
    end

    always_comb begin
        leds_next = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            unique case (mode_q[i])
                MODE_OFF:   leds_next[i] = 1'b0;
                MODE_ON:    leds_next[i] = 1'b1;
                MODE_BLINK: leds_next[i] = blink_phase;
                MODE_PWM:   leds_next[i] = (pwm_cnt < duty_active[i]);
                default:    leds_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_100_i) begin
        if (rst_i) begin
            leds_o <= '0;
        end else begin
            leds_o <= leds_next;
        end
    end

endmodule
